seq_alu: RTL

Parametrised, multi-cycle successor to the single-cycle datapath ALU.
- Adds shifts, XOR and unsigned compare.
- Adds an iterative multiplier and divider, which need a valid/ready handshake.
- Sits between the decode stage and writeback of the multi-cycle core. The controller issues one operation and waits for the result beat.

---
 rtl/seq_alu_pkg.sv | 37 +++
 rtl/seq_muldiv.sv | 106 ++++++++++
 rtl/seq_alu.sv | 112 +++++++++++
 3 files changed

// File: rtl/seq_alu_pkg.sv
// Shared opcodes, FSM state type and op-class helper for the sequential ALU.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SLT  = 4'd4;
  localparam logic [3:0] OP_SLTU = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_MULH = 4'd11;
  localparam logic [3:0] OP_DIV  = 4'd12;
  localparam logic [3:0] OP_REM  = 4'd13;

  // Mul/div sub-mode, equal to (op - OP_MUL) so the top can derive it by subtraction.
  localparam logic [1:0] MD_MUL  = 2'd0;
  localparam logic [1:0] MD_MULH = 2'd1;
  localparam logic [1:0] MD_DIV  = 2'd2;
  localparam logic [1:0] MD_REM  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_multicycle(input logic [31:0] o);
    return (o >= 32'(OP_MUL)) && (o <= 32'(OP_REM));
  endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Iterative shift-add multiplier / restoring divider with sign fix-up.
// Latency: WIDTH steps after start; last is high during the final step.
// Backpressure: none; the caller issues start only when idle and samples result when last is set.
// Ports: clk, rst (async high); start/mode/a/b capture an operation;
//        last flags the final step; result is the sign-corrected value after that step.
module seq_muldiv
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi, lo, d, a_raw;
  logic [1:0]       mode_q;
  logic             sa, sb, bz;

  logic             sgn_in, a_neg_in, b_neg_in, is_div, neg;
  logic [WIDTH-1:0] hi_n, lo_n, mulh_hi;
  logic [WIDTH:0]   sum, rsh, diff;

  // MUL keeps raw operands: low product bits are sign-agnostic.
  assign sgn_in   = (mode != MD_MUL);
  assign a_neg_in = sgn_in & a[WIDTH-1];
  assign b_neg_in = sgn_in & b[WIDTH-1];
  assign is_div   = mode_q[1];
  assign neg      = sa ^ sb;
  assign last     = (cnt == CW'(1));

  // One iteration step. hi holds partial product / remainder, lo holds
  // multiplier / quotient; both shift together.
  always_comb begin
    hi_n = hi;
    lo_n = lo;
    sum  = '0;
    rsh  = '0;
    diff = '0;
    if (is_div) begin
      rsh  = {hi, lo[WIDTH-1]};
      diff = rsh - {1'b0, d};
      if (!diff[WIDTH]) begin
        hi_n = diff[WIDTH-1:0];
        lo_n = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_n = rsh[WIDTH-1:0];
        lo_n = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      sum          = {1'b0, hi} + {1'b0, (lo[0] ? d : '0)};
      {hi_n, lo_n} = {sum, lo[WIDTH-1:1]};
    end
  end

  // High half of the negated 2*WIDTH product: ~hi plus the carry out of ~lo + 1.
  assign mulh_hi = neg ? (~hi_n + WIDTH'(lo_n == '0)) : hi_n;

  always_comb begin
    result = '0;
    case (mode_q)
      MD_MUL:  result = lo_n;
      MD_MULH: result = mulh_hi;
      MD_DIV:  result = bz ? '1 : (neg ? -lo_n : lo_n);
      MD_REM:  result = bz ? a_raw : (sa ? -hi_n : hi_n);
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      d      <= '0;
      a_raw  <= '0;
      mode_q <= MD_MUL;
      sa     <= 1'b0;
      sb     <= 1'b0;
      bz     <= 1'b0;
    end else if (start) begin
      cnt    <= CW'(WIDTH);
      hi     <= '0;
      lo     <= a_neg_in ? -a : a;
      d      <= b_neg_in ? -b : b;
      a_raw  <= a;
      mode_q <= mode;
      sa     <= a_neg_in;
      sb     <= b_neg_in;
      bz     <= (b == '0);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
      hi  <= hi_n;
      lo  <= lo_n;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-step simple ops plus iterative mul/div behind a valid/ready handshake.
// Latency: 1 cycle for simple/illegal ops, WIDTH+1 cycles for MUL/MULH/DIV/REM.
// Backpressure: one op in flight; in_ready only in IDLE, result held in DONE until out_ready.
// Ports: clk, rst (async high); in_valid/in_ready/op/a/b request side;
//        out_valid/out_ready/result/zero/err result side (err flags an illegal opcode).
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err
);

  localparam int SW = $clog2(WIDTH);

  state_t           state, state_n;
  logic             accept, multi, illegal;
  logic [WIDTH-1:0] simple_res, md_res;
  logic [SW-1:0]    shamt;
  logic             md_start, md_last;
  logic [1:0]       md_mode;

  assign shamt    = b[SW-1:0];
  assign multi    = is_multicycle(32'(op));
  assign accept   = in_valid & in_ready;
  assign md_start = accept & multi;
  assign md_mode  = 2'(op - OPW'(OP_MUL));

  seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .mode   (md_mode),
    .a      (a),
    .b      (b),
    .last   (md_last),
    .result (md_res)
  );

  always_comb begin
    simple_res = '0;
    illegal    = 1'b0;
    case (op)
      OPW'(OP_ADD):  simple_res = a + b;
      OPW'(OP_SUB):  simple_res = a - b;
      OPW'(OP_AND):  simple_res = a & b;
      OPW'(OP_OR):   simple_res = a | b;
      OPW'(OP_SLT):  simple_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OPW'(OP_SLTU): simple_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OPW'(OP_XOR):  simple_res = a ^ b;
      OPW'(OP_SLL):  simple_res = a << shamt;
      OPW'(OP_SRL):  simple_res = a >> shamt;
      OPW'(OP_SRA):  simple_res = $unsigned($signed(a) >>> shamt);
      OPW'(OP_MUL), OPW'(OP_MULH), OPW'(OP_DIV), OPW'(OP_REM): simple_res = '0;
      default:       illegal    = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept)    state_n = multi ? BUSY : DONE;
      BUSY:    if (md_last)   state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default:                state_n = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Result beat registers; only written on the edge that enters DONE, so they
  // stay frozen for the whole DONE stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
      zero   <= 1'b0;
      err    <= 1'b0;
    end else if (accept && !multi) begin
      result <= simple_res;
      zero   <= (simple_res == '0);
      err    <= illegal;
    end else if ((state == BUSY) && md_last) begin
      result <= md_res;
      zero   <= (md_res == '0);
      err    <= 1'b0;
    end
  end

endmodule
